// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: command-driven single/burst access controller that is the sole
// driver of an 8-entry register file port. Write beats stream in over a
// valid/ready handshake. Read beats stream out with backpressure. The burst
// address wraps modulo 2^ADDR_WIDTH.
module reg_file_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Cmd_Valid,
    output logic                  Cmd_Ready,
    input  logic                  Cmd_Op,
    input  logic [ADDR_WIDTH-1:0] Cmd_Addr,
    input  logic [2:0]            Cmd_Len,
    input  logic                  Wd_Valid,
    input  logic [DATA_WIDTH-1:0] Wd_Data,
    output logic                  Wd_Ready,
    output logic                  Rd_Valid,
    output logic [DATA_WIDTH-1:0] Rd_Data,
    output logic                  Rd_Last,
    input  logic                  Rd_Ready,
    output logic                  Busy,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [2:0]            beats_left_q, beats_left_d;

    // Next-state logic: command capture, per-beat address/count stepping.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        unique case (state_q)
            S_IDLE: begin
                if (Cmd_Valid) begin
                    cur_addr_d   = Cmd_Addr;
                    beats_left_d = Cmd_Len;
                    state_d      = Cmd_Op ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                if (Wd_Valid) begin
                    if (beats_left_q == 3'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cur_addr_d   = cur_addr_q + ADDR_WIDTH'(1);
                        beats_left_d = beats_left_q - 3'd1;
                    end
                end
            end
            S_READ: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (Rd_Ready) begin
                    if (beats_left_q == 3'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cur_addr_d   = cur_addr_q + ADDR_WIDTH'(1);
                        beats_left_d = beats_left_q - 3'd1;
                        state_d      = S_READ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset that abandons any burst in flight.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
        end
    end

    // Output decode from the registered state; everything is forced low while RST is high
    // so a reset mid-burst cannot produce one last WrEn/RdEn or Rd_Valid.
    always_comb begin
        Cmd_Ready = 1'b0;
        Wd_Ready  = 1'b0;
        Rd_Valid  = 1'b0;
        Rd_Data   = '0;
        Rd_Last   = 1'b0;
        Busy      = 1'b0;
        WrEn      = 1'b0;
        RdEn      = 1'b0;
        Address   = '0;
        WrData    = '0;
        if (!RST) begin
            Busy = (state_q != S_IDLE);
            unique case (state_q)
                S_IDLE: begin
                    Cmd_Ready = 1'b1;
                end
                S_WRITE: begin
                    Wd_Ready = 1'b1;
                    WrEn     = Wd_Valid;
                    Address  = cur_addr_q;
                    WrData   = Wd_Data;
                end
                S_READ: begin
                    RdEn    = 1'b1;
                    Address = cur_addr_q;
                end
                S_RESP: begin
                    Rd_Valid = 1'b1;
                    Rd_Data  = RdData;
                    Rd_Last  = (beats_left_q == 3'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl: directed stimulus with a scoreboard. Expected register
// file writes and read beats are queued as stimulus is issued; a monitor on
// the falling edge pops and compares them whenever the DUT presents WrEn or
// a read handshake. A behavioural register file sits on the DUT's RF port.
module tb_reg_file_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Cmd_Valid = 1'b0;
    logic          Cmd_Ready;
    logic          Cmd_Op = 1'b0;
    logic [AW-1:0] Cmd_Addr = '0;
    logic [2:0]    Cmd_Len = '0;
    logic          Wd_Valid = 1'b0;
    logic [DW-1:0] Wd_Data = '0;
    logic          Wd_Ready;
    logic          Rd_Valid;
    logic [DW-1:0] Rd_Data;
    logic          Rd_Last;
    logic          Rd_Ready = 1'b1;
    logic          Busy;
    logic          WrEn;
    logic          RdEn;
    logic [AW-1:0] Address;
    logic [DW-1:0] WrData;
    logic [DW-1:0] RdData = '0;

    reg_file_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op),
        .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len),
        .Wd_Valid(Wd_Valid), .Wd_Data(Wd_Data), .Wd_Ready(Wd_Ready),
        .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data), .Rd_Last(Rd_Last), .Rd_Ready(Rd_Ready),
        .Busy(Busy), .WrEn(WrEn), .RdEn(RdEn), .Address(Address),
        .WrData(WrData), .RdData(RdData)
    );

    always #5 CLK = ~CLK;

    // Behavioural register file: RdData updates only at an edge where RdEn is high.
    logic [DW-1:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = '0;
    always @(posedge CLK) begin
        if (WrEn) mem[Address] <= WrData;
        if (RdEn) RdData <= mem[Address];
    end

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { logic [DW-1:0] data; logic last; } rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: exclusivity every cycle, then scoreboard pops on RF writes and read handshakes.
    always @(negedge CLK) begin
        check("wr_rd_exclusive", {31'd0, WrEn & RdEn}, 32'd0);
        if (WrEn) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", {29'd0, Address}, {29'd0, e.addr});
                check("wr_data", {16'd0, WrData}, {16'd0, e.data});
            end
        end
        if (Rd_Valid && Rd_Ready) begin
            if (rd_q.size() == 0) begin
                check("unexpected_read", 32'd1, 32'd0);
            end else begin
                rd_t r;
                r = rd_q.pop_front();
                check("rd_data", {16'd0, Rd_Data}, {16'd0, r.data});
                check("rd_last", {31'd0, Rd_Last}, {31'd0, r.last});
            end
        end
    end

    function automatic void exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wr_q.push_back(e);
    endfunction

    function automatic void exp_rd(input logic [DW-1:0] d, input logic l);
        rd_t r;
        r.data = d;
        r.last = l;
        rd_q.push_back(r);
    endfunction

    // Offer a command and hold it until accepted; returns in the cycle after the accept edge.
    task automatic send_cmd(input logic op, input logic [AW-1:0] a, input logic [2:0] len);
        bit ok = 0;
        Cmd_Valid = 1'b1;
        Cmd_Op    = op;
        Cmd_Addr  = a;
        Cmd_Len   = len;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (Cmd_Ready) begin ok = 1; break; end
        end
        check("cmd_accept_timeout", {31'd0, ok}, 32'd1);
        @(posedge CLK); #1;
        Cmd_Valid = 1'b0;
    endtask

    task automatic write_beat(input logic [DW-1:0] d);
        bit ok = 0;
        Wd_Valid = 1'b1;
        Wd_Data  = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (Wd_Ready) begin ok = 1; break; end
        end
        check("wd_ready_timeout", {31'd0, ok}, 32'd1);
        @(posedge CLK); #1;
        Wd_Valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            if (!Busy) begin ok = 1; break; end
        end
        check("idle_timeout", {31'd0, ok}, 32'd1);
        @(posedge CLK); #1;
    endtask

    task automatic reset_outputs_zero(input string tag);
        check({tag, "_wren"},      {31'd0, WrEn},      32'd0);
        check({tag, "_rden"},      {31'd0, RdEn},      32'd0);
        check({tag, "_rd_valid"},  {31'd0, Rd_Valid},  32'd0);
        check({tag, "_busy"},      {31'd0, Busy},      32'd0);
        check({tag, "_cmd_ready"}, {31'd0, Cmd_Ready}, 32'd0);
    endtask

    initial begin
        int busy_cycles;
        bit ok;

        // Reset: two cycles high, outputs quiet, Cmd_Ready in first cycle after release.
        repeat (2) begin
            @(negedge CLK);
            reset_outputs_zero("reset");
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("post_reset_cmd_ready", {31'd0, Cmd_Ready}, 32'd1);
        check("post_reset_busy",      {31'd0, Busy},      32'd0);
        @(posedge CLK); #1;

        // Single write to address 3; Wd_Ready must be up in the cycle right after accept.
        exp_wr(3'd3, 16'hA5A5);
        send_cmd(1'b0, 3'd3, 3'd0);
        Wd_Valid = 1'b1;
        Wd_Data  = 16'hA5A5;
        @(negedge CLK);
        check("single_wr_ready", {31'd0, Wd_Ready}, 32'd1);
        @(posedge CLK); #1;
        Wd_Valid = 1'b0;
        @(negedge CLK);
        check("single_wr_back_idle", {31'd0, Cmd_Ready}, 32'd1);
        @(posedge CLK); #1;

        // Single read of address 3: RdEn at E+1, Rd_Valid at E+2.
        exp_rd(16'hA5A5, 1'b1);
        send_cmd(1'b1, 3'd3, 3'd0);
        @(negedge CLK);
        check("single_rd_rden",    {31'd0, RdEn},     32'd1);
        check("single_rd_addr",    {29'd0, Address},  32'd3);
        check("single_rd_early_v", {31'd0, Rd_Valid}, 32'd0);
        @(negedge CLK);
        check("single_rd_valid",   {31'd0, Rd_Valid}, 32'd1);
        wait_idle();

        // Burst write at 6, Len 3, wrapping to 0,1, with a 2-cycle gap after beat 2.
        exp_wr(3'd6, 16'd1);
        exp_wr(3'd7, 16'd2);
        exp_wr(3'd0, 16'd3);
        exp_wr(3'd1, 16'd4);
        send_cmd(1'b0, 3'd6, 3'd3);
        write_beat(16'd1);
        write_beat(16'd2);
        repeat (2) begin
            @(negedge CLK);
            check("wr_gap_busy", {31'd0, Busy}, 32'd1);
            @(posedge CLK); #1;
        end
        write_beat(16'd3);
        write_beat(16'd4);
        @(negedge CLK);
        check("burst_wr_done", {31'd0, Busy}, 32'd0);
        @(posedge CLK); #1;

        // Burst read back with wrap; Rd_Last only on beat 4.
        exp_rd(16'd1, 1'b0);
        exp_rd(16'd2, 1'b0);
        exp_rd(16'd3, 1'b0);
        exp_rd(16'd4, 1'b1);
        send_cmd(1'b1, 3'd6, 3'd3);
        wait_idle();

        // Backpressure: Rd_Ready low for 5 cycles while the first beat is presented.
        Rd_Ready = 1'b0;
        exp_rd(16'd3, 1'b0);
        exp_rd(16'd4, 1'b1);
        send_cmd(1'b1, 3'd0, 3'd1);
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (Rd_Valid) begin ok = 1; break; end
        end
        check("bp_valid_timeout", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, Rd_Valid}, 32'd1);
            check("bp_data",  {16'd0, Rd_Data},  32'd3);
            check("bp_last",  {31'd0, Rd_Last},  32'd0);
            check("bp_rden",  {31'd0, RdEn},     32'd0);
            if (i < 4) @(negedge CLK);
        end
        @(posedge CLK); #1;
        Rd_Ready = 1'b1;
        wait_idle();

        // Protocol: Cmd_Valid held through a 2-beat read; the next command waits for IDLE.
        exp_rd(16'd1, 1'b0);
        exp_rd(16'd2, 1'b1);
        exp_rd(16'd3, 1'b1);
        Cmd_Valid = 1'b1;
        Cmd_Op    = 1'b1;
        Cmd_Addr  = 3'd6;
        Cmd_Len   = 3'd1;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (Cmd_Ready) begin ok = 1; break; end
        end
        check("proto_first_accept", {31'd0, ok}, 32'd1);
        @(posedge CLK); #1;
        Cmd_Addr = 3'd0;
        Cmd_Len  = 3'd0;
        busy_cycles = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (Cmd_Ready) break;
            check("proto_busy_while_blocked", {31'd0, Busy}, 32'd1);
            busy_cycles++;
        end
        check("proto_busy_cycles", busy_cycles, 32'd4);
        @(posedge CLK); #1;
        Cmd_Valid = 1'b0;
        wait_idle();

        // Reset mid-burst: 2 of 4 beats written, then reset with a beat still offered.
        exp_wr(3'd6, 16'h0011);
        exp_wr(3'd7, 16'h0022);
        send_cmd(1'b0, 3'd6, 3'd3);
        write_beat(16'h0011);
        write_beat(16'h0022);
        RST      = 1'b1;
        Wd_Valid = 1'b1;
        Wd_Data  = 16'h0033;
        @(negedge CLK);
        check("midrst_wren",     {31'd0, WrEn},     32'd0);
        check("midrst_wd_ready", {31'd0, Wd_Ready}, 32'd0);
        reset_outputs_zero("midrst");
        @(posedge CLK); #1;
        RST      = 1'b0;
        Wd_Valid = 1'b0;
        @(negedge CLK);
        check("midrst_cmd_ready", {31'd0, Cmd_Ready}, 32'd1);
        check("midrst_busy",      {31'd0, Busy},      32'd0);
        check("midrst_mem0",      {16'd0, mem[0]},    32'd3);
        check("midrst_mem1",      {16'd0, mem[1]},    32'd4);
        check("midrst_mem6",      {16'd0, mem[6]},    32'h11);
        check("midrst_mem7",      {16'd0, mem[7]},    32'h22);
        @(posedge CLK); #1;

        // Read back across the partly rewritten window.
        exp_rd(16'h0011, 1'b0);
        exp_rd(16'h0022, 1'b0);
        exp_rd(16'd3, 1'b0);
        exp_rd(16'd4, 1'b1);
        send_cmd(1'b1, 3'd6, 3'd3);
        wait_idle();

        repeat (3) @(negedge CLK);
        check("wr_queue_drained", wr_q.size(), 32'd0);
        check("rd_queue_drained", rd_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_ctrl.md
# reg_file_ctrl

Command-driven access controller that sits in front of the 8-entry register file and is the sole driver of its WrEn/RdEn/Address/WrData port. It accepts single or burst read/write commands over a valid/ready handshake, streams write data in, and returns read data out with backpressure. Address increments per beat and wraps modulo 2^ADDR_WIDTH.

## Interface
- DATA_WIDTH, 16, register/data width
- ADDR_WIDTH, 3, register address width (register file depth = 2^ADDR_WIDTH)

- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- Cmd_Valid  in  1  command offered
- Cmd_Ready  out  1  controller can accept a command
- Cmd_Op  in  1  0 = write burst, 1 = read burst
- Cmd_Addr  in  ADDR_WIDTH  start address
- Cmd_Len  in  3  beats minus one (0..7 gives 1..8 beats)
- Wd_Valid  in  1  write data beat offered
- Wd_Data  in  DATA_WIDTH  write data beat
- Wd_Ready  out  1  controller accepts write beat
- Rd_Valid  out  1  read data beat valid
- Rd_Data  out  DATA_WIDTH  read data beat
- Rd_Last  out  1  final beat of read burst (qualified by Rd_Valid)
- Rd_Ready  in  1  consumer accepts read beat
- Busy  out  1  burst in progress
- WrEn  out  1  register file write enable
- RdEn  out  1  register file read enable
- Address  out  ADDR_WIDTH  register file address
- WrData  out  DATA_WIDTH  register file write data
- RdData  in  DATA_WIDTH  register file read data; updates at the edge where RdEn is sampled high and holds otherwise

## Operation
- Registers: state, cur_addr (ADDR_WIDTH), beats_left (3 bits).
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - Cmd_Ready = 1.
  - On Cmd_Valid: cur_addr <= Cmd_Addr, beats_left <= Cmd_Len.
  - Next state is WRITE if Cmd_Op = 0, else READ.
- WRITE:
  - Wd_Ready = 1. WrEn = Wd_Valid. Address = cur_addr. WrData = Wd_Data (combinational).
  - On Wd_Valid: if beats_left = 0, go to IDLE; else cur_addr + 1 (wraps), beats_left - 1.
- READ:
  - RdEn = 1 for exactly one cycle, Address = cur_addr.
  - Always goes to RESP.
- RESP:
  - Rd_Valid = 1, Rd_Data = RdData, Rd_Last = (beats_left = 0).
  - On Rd_Ready: if last, go to IDLE; else cur_addr + 1, beats_left - 1, go to READ.
- Output decodes:
  - Busy = (state != IDLE).
  - Cmd_Ready = (state = IDLE) and not RST.
  - All other outputs are 0 outside their state; Address = 0 and WrData = 0 when not driving.
- WrEn and RdEn are never high in the same cycle. The register file ignores that case, so it is a protocol violation.
- Cmd_Valid outside IDLE is ignored; the command is not queued.
- Wd_Valid outside WRITE is ignored. Rd_Ready outside RESP is ignored.
- Address wrap example: start 6, Len 3 accesses 6, 7, 0, 1.

## Timing
- Reset:
  - RST high at a rising edge forces state = IDLE, cur_addr = 0, beats_left = 0.
  - While RST is high: all outputs are 0, including Cmd_Ready.
  - First cycle after RST falls: Cmd_Ready = 1, Busy = 0.
- Write latency:
  - Command accepted at edge E. Wd_Ready = 1 from the cycle after E.
  - Each beat is written to the register file at the edge where Wd_Valid and Wd_Ready are both high.
  - Throughput is 1 beat/cycle.
- Read latency:
  - Command accepted at edge E. RdEn is high in cycle E+1. Rd_Valid is high from cycle E+2.
  - Each subsequent beat follows 2 cycles after the Rd_Ready handshake, giving peak throughput of 1 beat per 2 cycles.
- Backpressure:
  - While Rd_Valid is high and Rd_Ready is low, Rd_Data and Rd_Last are held stable.
  - RdEn stays 0, so RdData holds.
- The final handshake returns the controller to IDLE. Cmd_Ready = 1 in the very next cycle, so back-to-back commands have a 1-cycle gap.
- Reset mid-burst:
  - The burst is abandoned immediately. No further WrEn/RdEn pulses and no pending Rd_Valid.
  - Beats already written remain in the register file.

## Test plan
- Reset: RST high 2 cycles, then low -> during reset WrEn = RdEn = Rd_Valid = Busy = Cmd_Ready = 0; first post-reset cycle Cmd_Ready = 1.
- Single access:
  - Stimulus: write addr 3 with 16'hA5A5, then read addr 3, Len 0.
  - Required: exactly one WrEn cycle with Address = 3.
  - Required: RdEn 1 cycle after read accept, then Rd_Valid 2 cycles after accept with Rd_Data = 16'hA5A5 and Rd_Last = 1.
- Burst with wrap:
  - Stimulus: write Addr 6, Len 3, data 1, 2, 3, 4, with a 2-cycle Wd_Valid gap after beat 2. Then read Addr 6, Len 3.
  - Required: writes land at 6, 7, 0, 1.
  - Required: reads return 1, 2, 3, 4, with Rd_Last only on beat 4.
- Backpressure: hold Rd_Ready low 5 cycles during a read beat -> Rd_Valid, Rd_Data and Rd_Last stable; no RdEn pulse during the stall.
- Reset mid-burst:
  - Stimulus: assert RST after 2 of 4 write beats.
  - Required: only addresses 6 and 7 are updated in the model; controller returns to IDLE and Cmd_Ready = 1 after release.
- Protocol checks:
  - Stimulus: assert Cmd_Valid continuously during a burst.
  - Required: the command is not accepted until IDLE.
  - Required: assertion that WrEn and RdEn are never both 1, checked across all tests.
